zero_regfile: RTL and testbench

ZERO_REGFILE -- requirements
Module: zero_regfile

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clear_fsm.sv | 65 ++++++
 rtl/zero_regfile.sv | 94 +++++++++
 tb/tb_zero_regfile.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the zeroable register file.
// Holds the clear-FSM state encoding and the default bus geometry.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Register 0 is skipped by the sweep when it is hardwired to zero.
    function automatic int first_clear_addr(input int hardwire_zero);
        return (hardwire_zero != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks the file one register per cycle while busy is high.
// busy rises the edge after clr_req is seen in IDLE and falls after the last address.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(first_clear_addr(HARDWIRE_ZERO));
    localparam logic [ADDR_W-1:0] LAST  = '1;

    clr_state_t        state_q;
    clr_state_t        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter stops at LAST by compare and parks at zero, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = FIRST;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/zero_regfile.sv
// Two-read one-write register file with optional hardwired-zero register 0 and a bulk clear.
// Reads are registered (1 cycle) with write-first bypass; outputs read 0 while a clear runs.
module zero_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              clr_req,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit HZ    = (HARDWIRE_ZERO != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              wr_commit;
    logic              blank;
    logic [DATA_W-1:0] rd_a_nxt;
    logic [DATA_W-1:0] rd_b_nxt;

    regfile_clear_fsm #(
        .ADDR_W        (ADDR_W),
        .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // A clear request (even one arriving with a write) wins; busy drops writes outright.
    assign wr_commit = wr_en && !busy && !clr_req && !(HZ && (wr_addr == '0));
    assign blank     = busy || clr_req;

    always_comb begin
        rd_a_nxt = mem[rd_addr_a];
        if (HZ && (rd_addr_a == '0)) begin
            rd_a_nxt = '0;
        end
        if (wr_commit && (wr_addr == rd_addr_a)) begin
            rd_a_nxt = wr_data;
        end
        if (blank) begin
            rd_a_nxt = '0;
        end
    end

    always_comb begin
        rd_b_nxt = mem[rd_addr_b];
        if (HZ && (rd_addr_b == '0)) begin
            rd_b_nxt = '0;
        end
        if (wr_commit && (wr_addr == rd_addr_b)) begin
            rd_b_nxt = wr_data;
        end
        if (blank) begin
            rd_b_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_commit) begin
                mem[wr_addr] <= wr_data;
            end
            dout_a <= rd_a_nxt;
            dout_b <= rd_b_nxt;
        end
    end

endmodule

// File: tb/tb_zero_regfile.sv
// Scoreboarded bench: one instance with register 0 hardwired, one with it as plain storage.
// Reads push expected data; a negedge monitor pops and compares one cycle later.
module tb_zero_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        clr_req;
    logic [31:0] dout_a1, dout_b1, dout_a0, dout_b0;
    logic        busy1, busy0;

    always #5 clk = ~clk;

    zero_regfile #(.DATA_W(32), .ADDR_W(5), .HARDWIRE_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .clr_req(clr_req),
        .dout_a(dout_a1), .dout_b(dout_b1), .busy(busy1)
    );

    zero_regfile #(.DATA_W(32), .ADDR_W(5), .HARDWIRE_ZERO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .clr_req(clr_req),
        .dout_a(dout_a0), .dout_b(dout_b0), .busy(busy0)
    );

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    logic rd_chk = 1'b0;
    logic sample_q = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ea0, input logic [31:0] eb0);
        exp_t x;
        rd_addr_a = a;
        rd_addr_b = b;
        rd_chk    = 1'b1;
        x.name = nm; x.ea = ea; x.eb = eb; x.ea0 = ea0; x.eb0 = eb0;
        exp_q.push_back(x);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic step();
        @(negedge clk);
        wr_en   = 1'b0;
        clr_req = 1'b0;
        rd_chk  = 1'b0;
    endtask

    // Call after the edge that accepted clr_req. The hardwired file is busy 31 cycles, the other 32.
    task automatic sweep_check(input string nm, input bit traffic);
        for (int i = 0; i < 31; i++) begin
            check({nm, "_busy1"}, {31'd0, busy1}, 32'd1);
            check({nm, "_busy0"}, {31'd0, busy0}, 32'd1);
            if (traffic) begin
                wr(5'(i + 1), 32'hBAD0_0000 | 32'(i));
                clr_req = (i == 5);
                rd({nm, "_during"}, 5'(i + 1), 5'(31 - i), 0, 0, 0, 0);
            end
            step();
        end
        check({nm, "_end_busy1"}, {31'd0, busy1}, 32'd0);
        check({nm, "_end_busy0"}, {31'd0, busy0}, 32'd1);
        if (traffic) rd({nm, "_tail"}, 5'd3, 5'd31, 0, 0, 0, 0);
        step();
        check({nm, "_done_busy1"}, {31'd0, busy1}, 32'd0);
        check({nm, "_done_busy0"}, {31'd0, busy0}, 32'd0);
    endtask

    task automatic all_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            rd(nm, 5'(i), 5'(31 - i), 0, 0, 0, 0);
            step();
        end
    endtask

    always @(posedge clk) sample_q <= rd_chk;

    always @(negedge clk) begin
        if (sample_q) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_a_hz1"}, dout_a1, e.ea);
                check({e.name, "_b_hz1"}, dout_b1, e.eb);
                check({e.name, "_a_hz0"}, dout_a0, e.ea0);
                check({e.name, "_b_hz0"}, dout_b0, e.eb0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        step();
        step();
        check("reset_dout_a", dout_a1, 0);
        check("reset_dout_b", dout_b0, 0);
        check("reset_busy", {30'd0, busy1, busy0}, 0);
        rst_n = 1'b1;
        step();

        wr(5'd5, 32'hDEADBEEF); step();
        rd("basic_rd5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF); step();

        wr(5'd0, 32'h12345678); step();
        rd("addr0", 5'd0, 5'd0, 0, 0, 32'h12345678, 32'h12345678); step();

        wr(5'd7, 32'hA5A5A5A5);
        rd("bypass7", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5); step();
        rd("mixed", 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF); step();
        wr(5'd0, 32'h11);
        rd("bypass0", 5'd0, 5'd7, 0, 32'hA5A5A5A5, 32'h11, 32'hA5A5A5A5); step();

        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i));
            step();
        end
        rd("fill_hi", 5'd1, 5'd31, 1, 31, 1, 31); step();
        rd("fill_mid", 5'd0, 5'd16, 0, 16, 32'h11, 16); step();

        clr_req = 1'b1;
        wr(5'd3, 32'hFFFF_FFFF);
        rd("clr_start", 5'd3, 5'd31, 0, 0, 0, 0);
        step();
        sweep_check("sweep", 1'b1);
        all_zero("post_clear");

        wr(5'd20, 32'h77); step();
        clr_req = 1'b1; step();
        for (int i = 1; i < 10; i++) begin
            check("abort_busy", {31'd0, busy1}, 32'd1);
            step();
        end
        rst_n = 1'b0;
        clr_req = 1'b1;
        wr(5'd9, 32'h99);
        step();
        check("abort_busy_rst", {30'd0, busy1, busy0}, 0);
        check("abort_dout_a", dout_a1, 0);
        check("abort_dout_b", dout_b0, 0);
        rst_n = 1'b1;
        step();
        all_zero("post_abort");

        clr_req = 1'b1; step();
        sweep_check("resweep", 1'b0);

        step();
        step();
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
